// File: rtl/imem_loader_if.sv
// Byte-stream receive handshake and instruction-memory write port of the image loader.
// The slave side is the loader; the master side feeds bytes and observes the writes.
interface imem_loader_if #(
    parameter int unsigned ADDR_W = 8
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              IMWe;
    logic [ADDR_W-1:0] IMAddr;
    logic [31:0]       IMWData;

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready,
        input  IMWe,
        input  IMAddr,
        input  IMWData
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready,
        output IMWe,
        output IMAddr,
        output IMWData
    );
endinterface

// File: rtl/imem_loader.sv
// Loads a length-prefixed, XOR-checksummed program image into instruction memory,
// holding the processor until the whole image has been written and verified.
module imem_loader #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                start,
    imem_loader_if.slave        bus,
    output logic                cpu_hold,
    output logic                done,
    output logic                error
);

    typedef enum logic [2:0] {
        StIdle,
        StLen0,
        StLen1,
        StData,
        StChk,
        StDone,
        StErr
    } state_e;

    // Largest accepted word count; 17 bits so a 16-bit address space still fits.
    localparam logic [16:0] Cap = 17'd1 << ADDR_W;

    state_e            r_state, w_state;
    logic [15:0]       r_len, w_len;
    logic [1:0]        r_byte_cnt, w_byte_cnt;
    logic [16:0]       r_word_cnt, w_word_cnt;
    logic [7:0]        r_xor, w_xor;
    logic [23:0]       r_buf, w_buf;
    logic              r_we, w_we;
    logic [ADDR_W-1:0] r_addr, w_addr;
    logic [31:0]       r_wdata, w_wdata;

    logic              w_rx_ready;
    logic              w_xfer;
    logic [15:0]       w_n;
    logic [16:0]       w_word_inc;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state    <= StIdle;
            r_len      <= '0;
            r_byte_cnt <= '0;
            r_word_cnt <= '0;
            r_xor      <= '0;
            r_buf      <= '0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
        end else begin
            r_state    <= w_state;
            r_len      <= w_len;
            r_byte_cnt <= w_byte_cnt;
            r_word_cnt <= w_word_cnt;
            r_xor      <= w_xor;
            r_buf      <= w_buf;
            r_we       <= w_we;
            r_addr     <= w_addr;
            r_wdata    <= w_wdata;
        end
    end

    assign w_rx_ready = (r_state == StLen0) || (r_state == StLen1) ||
                        (r_state == StData) || (r_state == StChk);
    assign w_xfer     = bus.rx_valid & w_rx_ready;
    assign w_n        = {bus.rx_data, r_len[7:0]};
    assign w_word_inc = r_word_cnt + 17'd1;

    always_comb begin
        w_state    = r_state;
        w_len      = r_len;
        w_byte_cnt = r_byte_cnt;
        w_word_cnt = r_word_cnt;
        w_xor      = r_xor;
        w_buf      = r_buf;
        w_we       = 1'b0;
        w_addr     = r_addr;
        w_wdata    = r_wdata;

        unique case (r_state)
            StIdle, StDone, StErr: begin
                if (start) begin
                    w_state    = StLen0;
                    w_byte_cnt = '0;
                    w_word_cnt = '0;
                    w_xor      = '0;
                end
            end
            StLen0: begin
                if (w_xfer) begin
                    w_len[7:0] = bus.rx_data;
                    w_state    = StLen1;
                end
            end
            StLen1: begin
                if (w_xfer) begin
                    w_len = w_n;
                    if ({1'b0, w_n} > Cap) begin
                        w_state = StErr;
                    end else if (w_n == 16'd0) begin
                        w_state = StChk;
                    end else begin
                        w_state = StData;
                    end
                end
            end
            StData: begin
                if (w_xfer) begin
                    w_xor      = r_xor ^ bus.rx_data;
                    w_byte_cnt = r_byte_cnt + 2'd1;
                    unique case (r_byte_cnt)
                        2'd0: w_buf[7:0]   = bus.rx_data;
                        2'd1: w_buf[15:8]  = bus.rx_data;
                        2'd2: w_buf[23:16] = bus.rx_data;
                        default: begin
                            // Last byte of the word goes straight to the write port.
                            w_we       = 1'b1;
                            w_addr     = r_word_cnt[ADDR_W-1:0];
                            w_wdata    = {bus.rx_data, r_buf};
                            w_word_cnt = w_word_inc;
                            if (w_word_inc == {1'b0, r_len}) begin
                                w_state = StChk;
                            end
                        end
                    endcase
                end
            end
            StChk: begin
                if (w_xfer) begin
                    w_state = (bus.rx_data == r_xor) ? StDone : StErr;
                end
            end
            default: w_state = StIdle;
        endcase
    end

    assign bus.rx_ready = w_rx_ready;
    assign bus.IMWe     = r_we;
    assign bus.IMAddr   = r_addr;
    assign bus.IMWData  = r_wdata;
    assign cpu_hold     = (r_state != StDone);
    assign done         = (r_state == StDone);
    assign error        = (r_state == StErr);

endmodule
